// File: rtl/hls_deadlock_pkg.sv
// Shared types and defaults for the HLS deadlock watchdog and its helpers.
// No logic; pure declarations.
package hls_deadlock_pkg;

  typedef enum logic [4:0] {
    ST_IDLE    = 5'b00001,
    ST_MONITOR = 5'b00010,
    ST_SUSPECT = 5'b00100,
    ST_REPORT  = 5'b01000,
    ST_DRAIN   = 5'b10000
  } state_e;

  localparam int THRESH_DEFAULT = 1024;
  localparam int DL_COUNT_W     = 8;

endpackage

// File: rtl/hls_deadlock_prio_enc.sv
// Lowest-set-bit priority encoder; combinational, zero latency, no backpressure.
// vld is low and idx is 0 when no bit is set.
module hls_deadlock_prio_enc #(
  parameter int NUM_CH = 4,
  localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic [NUM_CH-1:0] vec,
  output logic [CH_W-1:0]   idx,
  output logic              vld
);

  // Scan downward so the lowest set bit is the last one written.
  always_comb begin
    idx = '0;
    vld = 1'b0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (vec[i]) begin
        idx = CH_W'(i);
        vld = 1'b1;
      end
    end
  end

endmodule

// File: rtl/hls_deadlock_watchdog_ctrl.sv
// Declares a partition-wide deadlock after THRESH consecutive stalled cycles and latches a report.
// Report rises THRESH-1 edges after the first stalled edge; held until ack, re-arms once blocks clear.
module hls_deadlock_watchdog_ctrl
  import hls_deadlock_pkg::*;
#(
  parameter int NUM_CH = 4,
  parameter int THRESH = THRESH_DEFAULT,
  parameter int CNT_W  = 16,
  localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  enable,
  input  logic [NUM_CH-1:0]     block_sigs,
  input  logic [NUM_CH-1:0]     idle_sigs,
  input  logic                  ack,
  output logic                  deadlock_valid,
  output logic [NUM_CH-1:0]     deadlock_mask,
  output logic [CH_W-1:0]       deadlock_ch,
  output logic [CNT_W-1:0]      stall_cycles,
  output logic [DL_COUNT_W-1:0] deadlock_count,
  output logic                  busy
);

  localparam logic [CNT_W-1:0] THRESH_C = CNT_W'(THRESH);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  state_e           state;
  logic             stalled;
  logic [CH_W-1:0]  first_ch;
  logic             first_vld;
  logic [CNT_W-1:0] cnt_inc;

  assign stalled = (&(block_sigs | idle_sigs)) && (|block_sigs);
  assign cnt_inc = stall_cycles + CNT_W'(1);
  assign busy    = (state == ST_SUSPECT) || (state == ST_REPORT) || (state == ST_DRAIN);

  hls_deadlock_prio_enc #(.NUM_CH(NUM_CH)) u_prio_enc (
    .vec (block_sigs),
    .idx (first_ch),
    .vld (first_vld)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state          <= ST_IDLE;
      stall_cycles   <= '0;
      deadlock_valid <= 1'b0;
      deadlock_mask  <= '0;
      deadlock_ch    <= '0;
      deadlock_count <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          stall_cycles <= '0;
          if (enable) state <= ST_MONITOR;
        end
        ST_MONITOR: begin
          if (!enable) begin
            state <= ST_IDLE;
          end else if (stalled && first_vld) begin
            state        <= ST_SUSPECT;
            stall_cycles <= CNT_W'(1);
            deadlock_ch  <= first_ch;
          end
        end
        ST_SUSPECT: begin
          if (!enable) begin
            state        <= ST_IDLE;
            stall_cycles <= '0;
          end else if (!stalled) begin
            // Any single non-stalled cycle restarts the count from scratch.
            state        <= ST_MONITOR;
            stall_cycles <= '0;
          end else begin
            stall_cycles <= cnt_inc;
            if (cnt_inc == THRESH_C) begin
              state          <= ST_REPORT;
              deadlock_valid <= 1'b1;
              deadlock_mask  <= block_sigs;
              if (deadlock_count != '1) deadlock_count <= deadlock_count + DL_COUNT_W'(1);
            end
          end
        end
        ST_REPORT: begin
          if (stalled && (stall_cycles != CNT_MAX)) stall_cycles <= cnt_inc;
          if (ack) begin
            deadlock_valid <= 1'b0;
            state          <= ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          if (block_sigs == '0) begin
            stall_cycles <= '0;
            state        <= enable ? ST_MONITOR : ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_hls_deadlock_watchdog_ctrl.sv
// Scoreboard bench for hls_deadlock_watchdog_ctrl: directed scenarios plus randomized traffic.
module tb_hls_deadlock_watchdog_ctrl;

  localparam int NUM_CH = 4;
  localparam int THRESH = 8;
  localparam int CNT_W  = 16;
  localparam int CH_W   = 2;
  localparam int MAXC   = (1 << CNT_W) - 1;

  logic              clock = 1'b0;
  logic              reset = 1'b1;
  logic              enable = 1'b0;
  logic [NUM_CH-1:0] block_sigs = '0;
  logic [NUM_CH-1:0] idle_sigs = '0;
  logic              ack = 1'b0;
  logic              deadlock_valid;
  logic [NUM_CH-1:0] deadlock_mask;
  logic [CH_W-1:0]   deadlock_ch;
  logic [CNT_W-1:0]  stall_cycles;
  logic [7:0]        deadlock_count;
  logic              busy;

  hls_deadlock_watchdog_ctrl #(.NUM_CH(NUM_CH), .THRESH(THRESH), .CNT_W(CNT_W)) dut (
    .clock          (clock),
    .reset          (reset),
    .enable         (enable),
    .block_sigs     (block_sigs),
    .idle_sigs      (idle_sigs),
    .ack            (ack),
    .deadlock_valid (deadlock_valid),
    .deadlock_mask  (deadlock_mask),
    .deadlock_ch    (deadlock_ch),
    .stall_cycles   (stall_cycles),
    .deadlock_count (deadlock_count),
    .busy           (busy)
  );

  always #5 clock = ~clock;

  typedef struct {
    bit       valid;
    int       stall;
    bit       busy;
    bit [3:0] mask;
    int       ch;
    int       count;
  } snap_t;

  typedef struct {
    bit [3:0] mask;
    int       ch;
    int       count;
  } rep_t;

  snap_t exp_q[$];
  rep_t  rep_q[$];

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      if (n_fail <= 50) $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: tracks run length of stalled cycles and the report/drain obligations.
  bit       m_armed, m_pending, m_drain;
  int       m_stall, m_count, m_ch;
  bit [3:0] m_mask;

  function automatic int lowest_bit(input bit [3:0] v);
    for (int i = 0; i < NUM_CH; i++) if (v[i]) return i;
    return 0;
  endfunction

  always @(posedge clock or posedge reset) begin
    if (reset) begin
      m_armed = 0; m_pending = 0; m_drain = 0;
      m_stall = 0; m_count = 0; m_ch = 0; m_mask = 0;
      exp_q.delete();
      rep_q.delete();
    end else begin
      bit   st;
      snap_t s;
      rep_t  r;
      st = ((block_sigs | idle_sigs) == 4'hF) && (block_sigs != 0);
      if (m_pending) begin
        if (st && m_stall < MAXC) m_stall++;
        if (ack) begin m_pending = 0; m_drain = 1; end
      end else if (m_drain) begin
        if (block_sigs == 0) begin m_drain = 0; m_stall = 0; m_armed = enable; end
      end else if (!m_armed) begin
        m_stall = 0;
        m_armed = enable;
      end else if (!enable) begin
        m_armed = 0;
        m_stall = 0;
      end else if (st) begin
        if (m_stall == 0) m_ch = lowest_bit(block_sigs);
        m_stall++;
        if (m_stall == THRESH) begin
          m_pending = 1;
          m_mask = block_sigs;
          if (m_count < 255) m_count++;
          r.mask = m_mask; r.ch = m_ch; r.count = m_count;
          rep_q.push_back(r);
        end
      end else begin
        m_stall = 0;
      end
      s.valid = m_pending;
      s.stall = m_stall;
      s.busy  = m_pending || m_drain || (m_stall > 0);
      s.mask  = m_mask;
      s.ch    = m_ch;
      s.count = m_count;
      exp_q.push_back(s);
    end
  end

  // Monitor: one expected snapshot per edge, plus a report record on each rising valid.
  bit prev_valid = 0;
  always @(negedge clock) begin
    if (reset) begin
      prev_valid = 0;
    end else begin
      if (exp_q.size() > 0) begin
        snap_t e;
        e = exp_q.pop_front();
        chk("valid", deadlock_valid, e.valid);
        chk("stall_cycles", stall_cycles, e.stall);
        chk("busy", busy, e.busy);
        chk("mask", deadlock_mask, e.mask);
        chk("ch", deadlock_ch, e.ch);
        chk("count", deadlock_count, e.count);
      end
      if (deadlock_valid && !prev_valid) begin
        if (rep_q.size() == 0) begin
          chk("unexpected_report", 1, 0);
        end else begin
          rep_t r;
          r = rep_q.pop_front();
          chk("report_mask", deadlock_mask, r.mask);
          chk("report_ch", deadlock_ch, r.ch);
          chk("report_count", deadlock_count, r.count);
        end
      end
      prev_valid = deadlock_valid;
    end
  end

  task automatic step(input bit en, input logic [3:0] b, input logic [3:0] i, input bit a);
    @(negedge clock);
    enable = en; block_sigs = b; idle_sigs = i; ack = a;
  endtask

  task automatic stepn(input int n, input bit en, input logic [3:0] b, input logic [3:0] i);
    for (int k = 0; k < n; k++) step(en, b, i, 1'b0);
  endtask

  task automatic ack_and_clear(input bit en);
    step(en, block_sigs, idle_sigs, 1'b1);
    stepn(2, en, block_sigs, idle_sigs);
    stepn(2, en, 4'b0000, 4'b0000);
  endtask

  initial begin
    int n;
    // Reset state
    #3;
    chk("rst_valid", deadlock_valid, 0);
    chk("rst_stall", stall_cycles, 0);
    chk("rst_count", deadlock_count, 0);
    chk("rst_busy", busy, 0);
    @(negedge clock);
    reset = 0;

    // 1: stall from a given edge, report after THRESH stalled edges
    stepn(3, 1'b1, 4'b0000, 4'b0000);
    step(1'b1, 4'b0100, 4'b1011, 1'b0);
    n = 0;
    do begin
      @(negedge clock);
      n++;
    end while (!deadlock_valid && n < 50);
    chk("t1_latency_edges", n, THRESH);
    chk("t1_mask", deadlock_mask, 4'b0100);
    chk("t1_ch", deadlock_ch, 2);
    chk("t1_count", deadlock_count, 1);

    // 3: ack while still blocked, then clear
    step(1'b1, 4'b0100, 4'b1011, 1'b1);
    step(1'b1, 4'b0100, 4'b1011, 1'b0);
    chk("t3_valid_after_ack", deadlock_valid, 0);
    chk("t3_busy_drain", busy, 1);
    step(1'b1, 4'b0000, 4'b0000, 1'b0);
    @(negedge clock);
    chk("t3_busy_monitor", busy, 0);

    // 2: one-cycle break in stall restarts counting
    stepn(4, 1'b1, 4'b0100, 4'b1011);
    step(1'b1, 4'b0100, 4'b1010, 1'b0);
    @(negedge clock);
    chk("t2_abort_stall", stall_cycles, 0);
    stepn(12, 1'b1, 4'b0100, 4'b1011);
    ack_and_clear(1'b1);

    // 4: enable drop during SUSPECT, then during REPORT
    stepn(3, 1'b1, 4'b0011, 4'b1100);
    stepn(2, 1'b0, 4'b0011, 4'b1100);
    chk("t4_idle_stall", stall_cycles, 0);
    stepn(12, 1'b1, 4'b1010, 4'b0101);
    stepn(6, 1'b0, 4'b1010, 4'b0101);
    chk("t4_report_held", deadlock_valid, 1);
    ack_and_clear(1'b0);

    // 5: long stall saturates the counter
    stepn(70000, 1'b1, 4'b1111, 4'b0000);
    chk("t5_stall_sat", stall_cycles, MAXC);
    chk("t5_valid_held", deadlock_valid, 1);
    ack_and_clear(1'b1);

    // Randomized traffic
    for (int seg = 0; seg < 300; seg++) begin
      int len, kind;
      logic [3:0] b, i;
      bit en;
      len  = $urandom_range(1, 14);
      kind = $urandom_range(0, 3);
      b = 4'($urandom);
      i = 4'($urandom);
      if (kind <= 1) begin
        if (b == 0) b = 4'b0001;
        i = ~b | 4'($urandom);
      end else if (kind == 2) begin
        b = 0;
      end
      en = ($urandom_range(0, 15) != 0);
      for (int k = 0; k < len; k++)
        step(en, b, i, ($urandom_range(0, 5) == 0));
    end
    stepn(3, 1'b1, 4'b0000, 4'b0000);

    // 6: async reset mid-REPORT
    stepn(12, 1'b1, 4'b0110, 4'b1001);
    @(posedge clock);
    #2 reset = 1;
    #1;
    chk("t6_valid", deadlock_valid, 0);
    chk("t6_mask", deadlock_mask, 0);
    chk("t6_ch", deadlock_ch, 0);
    chk("t6_stall", stall_cycles, 0);
    chk("t6_count", deadlock_count, 0);
    chk("t6_busy", busy, 0);
    @(negedge clock);
    reset = 0; enable = 1; block_sigs = 4'b1000; idle_sigs = 4'b0111; ack = 0;
    @(negedge clock);
    chk("t6_not_busy_monitor", busy, 0);
    @(negedge clock);
    chk("t6_suspect_stall", stall_cycles, 1);
    stepn(10, 1'b1, 4'b1000, 4'b0111);
    stepn(2, 1'b1, 4'b0000, 4'b0000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
